// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: control-bit layout, access sizes,
// exception vectors and the FSM state type.
package mem_pkg;

  localparam int unsigned CTRL_BUBBLE = 0;
  localparam int unsigned CTRL_RD     = 1;
  localparam int unsigned CTRL_WR     = 2;
  localparam int unsigned CTRL_SZ_LO  = 3;
  localparam int unsigned CTRL_SZ_HI  = 4;
  localparam int unsigned CTRL_SIGNED = 5;
  localparam int unsigned CTRL_REGW   = 6;
  localparam int unsigned CTRL_M2R    = 7;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [4:0] VEC_NONE = 5'd0;
  localparam logic [4:0] VEC_ADEL = 5'd4;
  localparam logic [4:0] VEC_ADES = 5'd5;

  localparam logic [7:0] BUBBLE_CTRL = 8'h01;

  typedef enum logic {S_IDLE, S_BUSY} lsu_state_t;

  // Byte accesses are always aligned; the unused size code is treated as a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  is_aligned = 1'b1;
      SIZE_H:  is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    case (st_size)
      SIZE_B: begin
        st_be    = 4'b0001 << st_addr;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        st_be    = 4'b0011 << st_addr;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = '0;
    case (ld_addr)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      2'd3: ld_byte = ld_rdata[31:24];
      default: ld_byte = '0;
    endcase
    ld_half = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SIZE_B:  ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SIZE_H:  ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues loads/stores over a req/ack handshake, stalls
// upstream while busy, flags misaligned accesses, and registers MEM/WB outputs.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned VEC_W    = 5,
  parameter logic [4:0]  VEC_ADEL = mem_pkg::VEC_ADEL,
  parameter logic [4:0]  VEC_ADES = mem_pkg::VEC_ADES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        control_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] sw_in,
  input  logic [4:0]        regdst_in,
  input  logic [VEC_W-1:0]  vector_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              mem_flush,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [7:0]        wb_control,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_regdst,
  output logic [VEC_W-1:0]  wb_vector,
  output logic [DATA_W-1:0] wb_pc
);

  lsu_state_t state, state_next;

  logic              is_mem, mem_op, misaligned, flushed;
  logic [1:0]        size_in;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_calc, load_data;
  logic [7:0]        hold_ctrl;
  logic [DATA_W-1:0] hold_alu, hold_pc;
  logic [4:0]        hold_regdst;

  assign size_in    = control_in[CTRL_SZ_HI:CTRL_SZ_LO];
  assign is_mem     = ~control_in[CTRL_BUBBLE] & (control_in[CTRL_RD] | control_in[CTRL_WR])
                      & (vector_in == '0);
  assign mem_op     = is_mem & is_aligned(size_in, alu_in[1:0]);
  assign misaligned = is_mem & ~is_aligned(size_in, alu_in[1:0]);

  // Stores use the live EX/MEM inputs; loads use the instruction latched at issue.
  mem_lane_align u_align (
    .st_size   (size_in),
    .st_addr   (alu_in[1:0]),
    .st_data   (sw_in),
    .st_be     (be_calc),
    .st_wdata  (wdata_calc),
    .ld_size   (hold_ctrl[CTRL_SZ_HI:CTRL_SZ_LO]),
    .ld_addr   (hold_alu[1:0]),
    .ld_signed (hold_ctrl[CTRL_SIGNED]),
    .ld_rdata  (dmem_rdata),
    .ld_data   (load_data)
  );

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      S_IDLE: begin
        mem_stall = mem_op & ~mem_flush;
        if (mem_op && !mem_flush) state_next = S_BUSY;
      end
      S_BUSY: begin
        mem_stall = ~dmem_ack;
        if (dmem_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      flushed     <= 1'b0;
      hold_ctrl   <= BUBBLE_CTRL;
      hold_alu    <= '0;
      hold_pc     <= '0;
      hold_regdst <= '0;
      wb_control  <= BUBBLE_CTRL;
      wb_data     <= '0;
      wb_regdst   <= '0;
      wb_vector   <= '0;
      wb_pc       <= '0;
    end else if (state == S_IDLE) begin
      if (mem_flush) begin
        wb_control <= BUBBLE_CTRL;
        wb_data    <= '0;
        wb_regdst  <= '0;
        wb_vector  <= '0;
        wb_pc      <= '0;
      end else if (vector_in != '0 || misaligned) begin
        wb_control <= BUBBLE_CTRL;
        wb_data    <= alu_in;
        wb_regdst  <= regdst_in;
        wb_pc      <= pc_in;
        if (vector_in != '0)            wb_vector <= vector_in;
        else if (control_in[CTRL_RD])   wb_vector <= VEC_ADEL;
        else                            wb_vector <= VEC_ADES;
      end else if (mem_op) begin
        dmem_req    <= 1'b1;
        dmem_we     <= control_in[CTRL_WR];
        dmem_addr   <= {alu_in[DATA_W-1:2], 2'b00};
        dmem_be     <= be_calc;
        dmem_wdata  <= wdata_calc;
        hold_ctrl   <= control_in;
        hold_alu    <= alu_in;
        hold_pc     <= pc_in;
        hold_regdst <= regdst_in;
        wb_control  <= BUBBLE_CTRL;
      end else begin
        wb_control <= control_in;
        wb_data    <= alu_in;
        wb_regdst  <= regdst_in;
        wb_vector  <= '0;
        wb_pc      <= pc_in;
      end
    end else begin
      // The request stays up until ack even if squashed; the result is discarded instead.
      if (dmem_ack) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        dmem_be  <= '0;
        flushed  <= 1'b0;
        if (flushed || mem_flush) begin
          wb_control <= BUBBLE_CTRL;
          wb_data    <= '0;
          wb_regdst  <= '0;
          wb_vector  <= '0;
          wb_pc      <= '0;
        end else begin
          wb_control <= hold_ctrl;
          wb_data    <= hold_ctrl[CTRL_M2R] ? load_data : hold_alu;
          wb_regdst  <= hold_regdst;
          wb_vector  <= '0;
          wb_pc      <= hold_pc;
        end
      end else if (mem_flush) begin
        flushed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against a behavioural
// model of the MEM-stage load/store rules.
module tb_mem_stage_lsu;

  logic        clk, reset;
  logic [7:0]  control_in;
  logic [31:0] alu_in, sw_in, pc_in;
  logic [4:0]  regdst_in, vector_in;
  logic        mem_flush, mem_stall;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [7:0]  wb_control;
  logic [31:0] wb_data, wb_pc;
  logic [4:0]  wb_regdst, wb_vector;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu #(.DATA_W(32), .VEC_W(5)) dut (
    .clk(clk), .reset(reset), .control_in(control_in), .alu_in(alu_in),
    .sw_in(sw_in), .regdst_in(regdst_in), .vector_in(vector_in), .pc_in(pc_in),
    .mem_flush(mem_flush), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_control(wb_control), .wb_data(wb_data), .wb_regdst(wb_regdst),
    .wb_vector(wb_vector), .wb_pc(wb_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic rd, input logic wr, input logic [1:0] sz,
                                    input logic sg, input logic rw, input logic m2r);
    return {m2r, rw, sg, sz, wr, rd, 1'b0};
  endfunction

  function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 32'd1 << a[1:0];
    if (sz == 2'b01) return 32'd3 << a[1:0];
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sw);
    if (sz == 2'b00) return (sw & 32'hFF) * 32'h01010101;
    if (sz == 2'b01) return (sw & 32'hFFFF) * 32'h00010001;
    return sw;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a[1:0]);
    if (sz == 2'b00) begin
      v = v & 32'hFF;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32768) v = v - 65536;
    end else v = rd;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [7:0] c, input logic [31:0] a, input logic [31:0] s,
                           input logic [4:0] r, input logic [4:0] v, input logic [31:0] p);
    control_in = c; alu_in = a; sw_in = s; regdst_in = r; vector_in = v; pc_in = p;
  endtask

  task automatic set_idle();
    set_instr(8'h01, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
  endtask

  task automatic run_alu(input logic [7:0] c, input logic [31:0] a, input logic [4:0] r,
                         input logic [31:0] p);
    set_instr(c, a, 32'h0, r, 5'd0, p);
    #1 chk("alu_stall", mem_stall, 0);
    tick();
    chk("alu_ctrl", wb_control, c);
    chk("alu_data", wb_data, a);
    chk("alu_rd", wb_regdst, r);
    chk("alu_pc", wb_pc, p);
    chk("alu_vec", wb_vector, 0);
    chk("alu_req", dmem_req, 0);
  endtask

  task automatic run_misaligned(input logic [7:0] c, input logic [31:0] a, input logic [31:0] p);
    set_instr(c, a, 32'h5555AAAA, 5'd9, 5'd0, p);
    #1 chk("mis_stall", mem_stall, 0);
    tick();
    chk("mis_req", dmem_req, 0);
    chk("mis_vec", wb_vector, c[1] ? 32'd4 : 32'd5);
    chk("mis_ctrl", wb_control, 8'h01);
    chk("mis_pc", wb_pc, p);
    set_idle();
  endtask

  task automatic run_mem(input logic [7:0] c, input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] r, input logic [31:0] p, input int delay,
                         input logic [31:0] rdata, input int flush_at);
    int stalls;
    logic [31:0] exp_data;
    stalls = 0;
    set_instr(c, a, s, r, 5'd0, p);
    #1;
    chk("mem_stall_issue", mem_stall, 1);
    chk("mem_req_issue", dmem_req, 0);
    if (mem_stall) stalls++;
    tick();
    chk("mem_wb_bubble", wb_control, 8'h01);
    for (int k = 0; k < delay; k++) begin
      chk("busy_req", dmem_req, 1);
      chk("busy_addr", dmem_addr, a & ~32'h3);
      chk("busy_we", dmem_we, c[2]);
      chk("busy_be", dmem_be, m_be(c[4:3], a));
      if (c[2]) chk("busy_wdata", dmem_wdata, m_wdata(c[4:3], s));
      mem_flush = (k == flush_at);
      #1;
      if (mem_stall) stalls++;
      tick();
      mem_flush = 1'b0;
    end
    chk("ack_req", dmem_req, 1);
    chk("ack_be", dmem_be, m_be(c[4:3], a));
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    #1;
    chk("ack_stall", mem_stall, 0);
    chk("stall_cycles", stalls, delay + 1);
    tick();
    dmem_ack = 1'b0;
    set_idle();
    chk("post_req", dmem_req, 0);
    if (flush_at >= 0) begin
      chk("fl_ctrl", wb_control, 8'h01);
      chk("fl_data", wb_data, 0);
      chk("fl_rd", wb_regdst, 0);
    end else begin
      exp_data = c[7] ? m_load(c[4:3], c[5], a, rdata) : a;
      chk("wb_ctrl", wb_control, c);
      chk("wb_data", wb_data, exp_data);
      chk("wb_rd", wb_regdst, r);
      chk("wb_pc", wb_pc, p);
      chk("wb_vec", wb_vector, 0);
    end
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] a;
    logic [1:0]  sz;
    reset = 1'b0; mem_flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_idle();
    #12;
    chk("rst_ctrl", wb_control, 8'h01);
    chk("rst_req", dmem_req, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_data", wb_data, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    run_alu(mk(0, 0, 2'b10, 0, 1, 0), 32'h12345678, 5'd3, 32'h400);

    // Reset asserted while an access is outstanding.
    set_instr(mk(1, 0, 2'b10, 0, 1, 1), 32'h100, 32'h0, 5'd7, 5'd0, 32'h404);
    tick();
    chk("rb_req", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rb_req_drop", dmem_req, 0);
    chk("rb_ctrl", wb_control, 8'h01);
    set_idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_alu(mk(0, 0, 2'b10, 0, 1, 0), 32'hCAFE0001, 5'd4, 32'h408);

    run_mem(mk(1, 0, 2'b10, 0, 1, 1), 32'h100, 32'h0, 5'd12, 32'h40C, 3, 32'hDEADBEEF, -1);
    run_mem(mk(1, 0, 2'b00, 1, 1, 1), 32'h103, 32'h0, 5'd5, 32'h410, 1, 32'h80112233, -1);
    run_mem(mk(1, 0, 2'b00, 0, 1, 1), 32'h103, 32'h0, 5'd5, 32'h414, 0, 32'h80112233, -1);
    run_mem(mk(0, 1, 2'b01, 0, 0, 0), 32'h202, 32'h1234ABCD, 5'd0, 32'h418, 1, 32'h0, -1);
    run_misaligned(mk(1, 0, 2'b10, 0, 1, 1), 32'h101, 32'h41C);
    run_misaligned(mk(0, 1, 2'b01, 0, 0, 0), 32'h203, 32'h420);
    run_mem(mk(0, 1, 2'b10, 0, 0, 0), 32'h300, 32'h11223344, 5'd0, 32'h424, 2, 32'h0, 0);
    run_alu(mk(0, 0, 2'b10, 0, 1, 0), 32'h0BADF00D, 5'd8, 32'h428);

    // Exception from EX passes through without an access.
    set_instr(mk(1, 0, 2'b10, 0, 1, 1), 32'h500, 32'h0, 5'd2, 5'd3, 32'h42C);
    #1 chk("exc_stall", mem_stall, 0);
    tick();
    chk("exc_req", dmem_req, 0);
    chk("exc_vec", wb_vector, 3);
    chk("exc_ctrl", wb_control, 8'h01);
    // Flush in IDLE drops a memory op.
    set_instr(mk(1, 0, 2'b10, 0, 1, 1), 32'h600, 32'h0, 5'd2, 5'd0, 32'h430);
    mem_flush = 1'b1;
    #1 chk("fi_stall", mem_stall, 0);
    tick();
    mem_flush = 1'b0;
    set_idle();
    chk("fi_req", dmem_req, 0);
    chk("fi_ctrl", wb_control, 8'h01);
    chk("fi_pc", wb_pc, 0);

    for (int i = 0; i < 30; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = {$urandom_range(16'h0100, 16'h7FFF), 16'h0} | 32'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: run_alu(mk(0, 0, sz, 0, 1, 0), $urandom, 5'($urandom), $urandom);
        1: begin
          if (sz == 2'b01) a[0] = 1'b0;
          if (sz == 2'b10) a[1:0] = 2'b00;
          c = mk(1, 0, sz, 1'($urandom), 1, 1);
          run_mem(c, a, 32'h0, 5'($urandom), $urandom, $urandom_range(0, 3), $urandom, -1);
        end
        2: begin
          if (sz == 2'b01) a[0] = 1'b0;
          if (sz == 2'b10) a[1:0] = 2'b00;
          c = mk(0, 1, sz, 0, 0, 0);
          run_mem(c, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3), 32'h0, -1);
        end
        default: begin
          sz = 2'($urandom_range(1, 2));
          a[0] = 1'b1;
          run_misaligned(mk(1'($urandom), 1, sz, 0, 1, 0), a, $urandom);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
